// File: rtl/ic74hc151_pkg.sv
// Shared constants for the ic74hc151 scan multiplexer: FSM state encoding
// and the Mode_Part input values.
package ic74hc151_pkg;

  // Operating state, chosen afresh on every edge from EN_Part / Mode_Part.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  // Mode_Part encoding.
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/ic74hc151_next_chan.sv
// Combinational next-channel finder for auto-scan. Given the current channel
// and a skip mask (1 = skip), returns the next unmasked channel in ascending
// order with wrap-around. The current channel is considered last, so a lone
// unmasked current channel yields itself. none_valid flags an all-masked set.
// A current channel outside 0..N-1 (left by a manual select) scans on from 0.
module ic74hc151_next_chan
  import ic74hc151_pkg::*;
#(
  parameter int DATA_SelectPart  = 3,
  parameter int DATA_Single_Part = 8
) (
  input  logic [DATA_SelectPart-1:0]  chan,
  input  logic [DATA_Single_Part-1:0] mask,
  output logic [DATA_SelectPart-1:0]  next_chan,
  output logic                        none_valid
);

  localparam int N = DATA_Single_Part;

  // Walk offsets 1..N from the current channel and keep the first unmasked hit.
  always_comb begin
    int   base;
    int   cand;
    logic cand_ok;
    logic found;
    next_chan = chan;
    none_valid = 1'b1;
    found = 1'b0;
    cand = 0;
    cand_ok = 1'b0;
    base = (int'(chan) >= N) ? N - 1 : int'(chan);
    for (int k = 1; k <= N; k++) begin
      cand = base + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_ok = 1'b0;
      for (int c = 0; c < N; c++) begin
        if (c == cand) begin
          cand_ok = ~mask[c];
        end
      end
      if (cand_ok && !found) begin
        found = 1'b1;
        next_chan = DATA_SelectPart'(cand);
      end
    end
    none_valid = ~found;
  end

endmodule

// File: rtl/ic74hc151_scan_mux.sv
// Clocked, parametrised 74HC151-style data selector with manual and
// auto-scan modes and a registered true/complement output pair.
// Optional build macro SCAN_MASK_EN adds the Mask_Part skip mask for scanning.
module ic74hc151_scan_mux
  import ic74hc151_pkg::*;
#(
  parameter int DATA_SelectPart  = 3,
  parameter int DATA_Single_Part = 8,
  parameter int DWELL_W          = 8
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        EN_Part,
  input  logic                        Mode_Part,
  input  logic [DATA_SelectPart-1:0]  SelectPart,
  input  logic [DATA_Single_Part-1:0] Single_Part,
`ifdef SCAN_MASK_EN
  input  logic [DATA_Single_Part-1:0] Mask_Part,
`endif
  input  logic [DWELL_W-1:0]          Dwell_Part,
  output logic                        Y,
  output logic                        YF,
  output logic [DATA_SelectPart-1:0]  ChanPart,
  output logic                        Step_Part
);

  localparam int N = DATA_Single_Part;

  state_t                       state_reg;
  state_t                       state_next;
  logic [DATA_SelectPart-1:0]   chan_reg;
  logic [DATA_SelectPart-1:0]   chan_next;
  logic [DWELL_W-1:0]           cnt_reg;
  logic [DWELL_W-1:0]           cnt_next;
  logic [DWELL_W-1:0]           cnt_cur;
  logic                         y_reg;
  logic                         yf_reg;
  logic                         step_reg;
  logic                         y_next;
  logic                         step_next;
  logic                         force_zero;
  logic [DATA_SelectPart-1:0]   scan_chan;
  logic                         none_valid;
  logic [N-1:0]                 scan_mask;
  logic [N-1:0]                 hit;

`ifdef SCAN_MASK_EN
  assign scan_mask = Mask_Part;
`else
  assign scan_mask = '0;
`endif

  ic74hc151_next_chan #(
    .DATA_SelectPart (DATA_SelectPart),
    .DATA_Single_Part(DATA_Single_Part)
  ) u_next_chan (
    .chan      (chan_reg),
    .mask      (scan_mask),
    .next_chan (scan_chan),
    .none_valid(none_valid)
  );

  // Data bit of the channel ChanPart takes this edge; out-of-range selects give 0.
  for (genvar gi = 0; gi < N; gi++) begin : g_hit
    assign hit[gi] = (int'(chan_next) == gi) && Single_Part[gi];
  end

  assign y_next    = ~force_zero & (|hit);
  assign step_next = (state_next != ST_IDLE) && (chan_next != chan_reg);

  // Next state from the enable/mode pins, plus channel and dwell-count updates.
  always_comb begin
    state_next = ST_IDLE;
    if (!EN_Part) begin
      state_next = (Mode_Part == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
    end
    chan_next = chan_reg;
    cnt_next = '0;
    cnt_cur = '0;
    force_zero = 1'b0;
    case (state_next)
      ST_MANUAL: begin
        chan_next = SelectPart;
      end
      ST_SCAN: begin
        // Entering scan from another state always starts a fresh dwell.
        cnt_cur = (state_reg == ST_SCAN) ? cnt_reg : '0;
        if (cnt_cur >= Dwell_Part) begin
          cnt_next = '0;
          chan_next = scan_chan;
        end else begin
          cnt_next = cnt_cur + DWELL_W'(1);
        end
        if (none_valid) begin
          force_zero = 1'b1;
        end
      end
      default: begin
        force_zero = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Channel, dwell counter and registered output pair.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      chan_reg <= '0;
      cnt_reg  <= '0;
      y_reg    <= 1'b0;
      yf_reg   <= 1'b1;
      step_reg <= 1'b0;
    end else begin
      chan_reg <= chan_next;
      cnt_reg  <= cnt_next;
      y_reg    <= y_next;
      yf_reg   <= ~y_next;
      step_reg <= step_next;
    end
  end

  assign Y         = y_reg;
  assign YF        = yf_reg;
  assign ChanPart  = chan_reg;
  assign Step_Part = step_reg;

endmodule

// File: tb/tb_ic74hc151_scan_mux.sv
// Self-checking bench for ic74hc151_scan_mux: directed scenarios plus
// randomized traffic against a behavioural model; a second small instance
// (2-bit select, 3 channels) covers wrap and out-of-range select.
module tb_ic74hc151_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       mode = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] data = '0;
  logic [7:0] mask = '0;
  logic [7:0] dwell = '0;
  logic       y, yf, step;
  logic [2:0] chan;

  logic       s_en = 1'b1;
  logic       s_mode = 1'b0;
  logic [1:0] s_sel = '0;
  logic [2:0] s_data = '0;
  logic [2:0] s_mask = '0;
  logic [7:0] s_dwell = '0;
  logic       s_y, s_yf, s_step;
  logic [1:0] s_chan;

  int checks = 0;
  int failures = 0;

  // Behavioural model of the 8-channel instance.
  int   m_chan = 0;
  int   m_held = 0;
  logic m_y = 1'b0;
  logic m_step = 1'b0;
  logic m_in_scan = 1'b0;

  always #5 clk = ~clk;

  ic74hc151_scan_mux #(.DATA_SelectPart(3), .DATA_Single_Part(8), .DWELL_W(8)) dut (
    .Clk(clk), .Rst_n(rst_n), .EN_Part(en), .Mode_Part(mode), .SelectPart(sel),
    .Single_Part(data),
`ifdef SCAN_MASK_EN
    .Mask_Part(mask),
`endif
    .Dwell_Part(dwell), .Y(y), .YF(yf), .ChanPart(chan), .Step_Part(step)
  );

  ic74hc151_scan_mux #(.DATA_SelectPart(2), .DATA_Single_Part(3), .DWELL_W(8)) dut_small (
    .Clk(clk), .Rst_n(rst_n), .EN_Part(s_en), .Mode_Part(s_mode), .SelectPart(s_sel),
    .Single_Part(s_data),
`ifdef SCAN_MASK_EN
    .Mask_Part(s_mask),
`endif
    .Dwell_Part(s_dwell), .Y(s_y), .YF(s_yf), .ChanPart(s_chan), .Step_Part(s_step)
  );

  // Next channel to visit: smallest unmasked channel above c, else the lowest one.
  function automatic int next_unmasked(int c, logic [7:0] mk);
    int q[$];
    for (int i = 0; i < 8; i++) if (!mk[i]) q.push_back(i);
    if (q.size() == 0) return c;
    foreach (q[i]) if (q[i] > c) return q[i];
    return q[0];
  endfunction

  function automatic logic [5:0] exp_vec();
    logic [2:0] c3;
    c3 = m_chan[2:0];
    return {m_y, ~m_y, c3, m_step};
  endfunction

  task automatic model_reset();
    m_chan = 0; m_held = 0; m_y = 1'b0; m_step = 1'b0; m_in_scan = 1'b0;
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_edge();
    int newc;
    if (en) begin
      m_y = 1'b0; m_step = 1'b0; m_held = 0; m_in_scan = 1'b0;
    end else if (mode == 1'b0) begin
      m_step = (int'(sel) != m_chan);
      m_chan = int'(sel);
      m_y = data[m_chan];
      m_held = 0; m_in_scan = 1'b0;
    end else begin
      if (!m_in_scan) m_held = 0;
      newc = m_chan;
      m_held++;                       // edges spent on this channel so far
      if (m_held > int'(dwell)) begin // each channel lasts Dwell+1 edges
        m_held = 0;
        newc = next_unmasked(m_chan, mask);
      end
      m_step = (newc != m_chan);
      m_chan = newc;
      m_y = (mask == 8'hFF) ? 1'b0 : data[m_chan];
      m_in_scan = 1'b1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({y, yf, chan, step} !== 6'b01_000_0) begin
      failures++; $display("FAIL reset_init got=%b exp=%b", {y, yf, chan, step}, 6'b01_000_0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    en = 1'b0; mode = 1'b1; dwell = 8'd1; data = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({y, yf, chan, step} !== exp_vec()) begin
        failures++; $display("FAIL reset_prescan cyc=%0d got=%b exp=%b", i, {y, yf, chan, step}, exp_vec());
      end
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({y, yf, chan, step} !== 6'b01_000_0) begin
      failures++; $display("FAIL reset_async got=%b exp=%b", {y, yf, chan, step}, 6'b01_000_0);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_manual();
    en = 1'b0; mode = 1'b0; data = 8'b1011_1101; sel = 3'd3;
    tick();
    checks++;
    if ({y, yf, chan, step} !== 6'b10_011_1) begin
      failures++; $display("FAIL manual_sel3 got=%b exp=%b", {y, yf, chan, step}, 6'b10_011_1);
    end
    tick();
    checks++;
    if ({y, yf, chan, step} !== exp_vec()) begin
      failures++; $display("FAIL manual_hold got=%b exp=%b", {y, yf, chan, step}, exp_vec());
    end
    sel = 3'd1;
    tick();
    checks++;
    if ({y, yf, chan, step} !== 6'b01_001_1) begin
      failures++; $display("FAIL manual_sel1 got=%b exp=%b", {y, yf, chan, step}, 6'b01_001_1);
    end
    $display("test_manual done");
  endtask

  task automatic test_idle();
    en = 1'b1;
    tick();
    checks++;
    if ({y, yf, chan, step} !== 6'b01_001_0) begin
      failures++; $display("FAIL idle_enter got=%b exp=%b", {y, yf, chan, step}, 6'b01_001_0);
    end
    en = 1'b0;
    tick();
    checks++;
    if ({chan, step} !== 4'b001_0 || {y, yf, chan, step} !== exp_vec()) begin
      failures++; $display("FAIL idle_reenable got=%b exp=%b", {y, yf, chan, step}, exp_vec());
    end
    $display("test_idle done");
  endtask

  task automatic test_scan();
    int steps;
    steps = 0;
    mode = 1'b0; sel = 3'd0; data = 8'b1011_1101;
    tick();
    mode = 1'b1; dwell = 8'd2;
    for (int i = 0; i < 24; i++) begin
      tick();
      steps += int'(step);
      checks++;
      if ({y, yf, chan, step} !== exp_vec()) begin
        failures++; $display("FAIL scan_d2 cyc=%0d got=%b exp=%b", i, {y, yf, chan, step}, exp_vec());
      end
    end
    checks++;
    if (steps != 8 || chan !== 3'd0) begin
      failures++; $display("FAIL scan_d2_pulses got=%0d/ch%0d exp=8/ch0", steps, chan);
    end
    $display("test_scan done steps=%0d", steps);
  endtask

  task automatic test_dwell0();
    dwell = 8'd0;
    for (int i = 0; i < 12; i++) begin
      data = 8'($urandom);
      tick();
      checks++;
      if (step !== 1'b1 || {y, yf, chan, step} !== exp_vec()) begin
        failures++; $display("FAIL scan_d0 cyc=%0d got=%b exp=%b", i, {y, yf, chan, step}, exp_vec());
      end
    end
    $display("test_dwell0 done");
  endtask

  task automatic test_dwell_lower();
    dwell = 8'd20;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({y, yf, chan, step} !== exp_vec()) begin
        failures++; $display("FAIL dwell_long cyc=%0d got=%b exp=%b", i, {y, yf, chan, step}, exp_vec());
      end
    end
    dwell = 8'd1;
    tick();
    checks++;
    if (step !== 1'b1 || {y, yf, chan, step} !== exp_vec()) begin
      failures++; $display("FAIL dwell_lowered got=%b exp=%b", {y, yf, chan, step}, exp_vec());
    end
    $display("test_dwell_lower done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) mode = ~mode;
      sel = 3'($urandom);
      data = 8'($urandom);
      if ($urandom_range(0, 9) == 0) dwell = 8'($urandom_range(0, 3));
`ifdef SCAN_MASK_EN
      if ($urandom_range(0, 15) == 0) mask = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom & $urandom);
`endif
      tick();
      checks++;
      if ({y, yf, chan, step} !== exp_vec()) begin
        failures++; $display("FAIL random cyc=%0d got=%b exp=%b", i, {y, yf, chan, step}, exp_vec());
      end
    end
    mask = '0;
    $display("test_random done");
  endtask

  task automatic test_small();
    int   exp_c[4] = '{1, 2, 0, 1};
    logic exp_y[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    en = 1'b1;
    s_en = 1'b0; s_mode = 1'b0; s_sel = 2'd0; s_data = 3'b101; s_dwell = 8'd0;
    tick();
    checks++;
    if ({s_y, s_yf, s_chan} !== 4'b10_00) begin
      failures++; $display("FAIL small_manual0 got=%b exp=%b", {s_y, s_yf, s_chan}, 4'b10_00);
    end
    s_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (int'(s_chan) != exp_c[i] || s_y !== exp_y[i] || s_yf !== ~exp_y[i] || s_step !== 1'b1) begin
        failures++;
        $display("FAIL small_wrap cyc=%0d got=ch%0d y%b st%b exp=ch%0d y%b st1", i, s_chan, s_y, s_step, exp_c[i], exp_y[i]);
      end
    end
    s_mode = 1'b0; s_sel = 2'd3;
    tick();
    checks++;
    if ({s_y, s_yf, s_chan, s_step} !== 5'b01_11_1) begin
      failures++; $display("FAIL small_oor got=%b exp=%b", {s_y, s_yf, s_chan, s_step}, 5'b01_11_1);
    end
    s_sel = 2'd2;
    tick();
    checks++;
    if ({s_y, s_yf, s_chan} !== 4'b10_10) begin
      failures++; $display("FAIL small_sel2 got=%b exp=%b", {s_y, s_yf, s_chan}, 4'b10_10);
    end
    s_en = 1'b1;
    $display("test_small done");
  endtask

`ifdef SCAN_MASK_EN
  task automatic test_mask();
    int   exp_c[4] = '{1, 3, 1, 3};
    logic [2:0] held;
    en = 1'b0; mode = 1'b0; sel = 3'd3; data = 8'($urandom);
    tick();
    mask = 8'b1111_0101; mode = 1'b1; dwell = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (int'(chan) != exp_c[i] || {y, yf, chan, step} !== exp_vec()) begin
        failures++; $display("FAIL mask_seq cyc=%0d got=%b exp=%b", i, {y, yf, chan, step}, exp_vec());
      end
    end
    held = chan;
    mask = 8'hFF; data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({y, yf, chan, step} !== {2'b01, held, 1'b0}) begin
        failures++; $display("FAIL mask_all cyc=%0d got=%b exp=%b", i, {y, yf, chan, step}, {2'b01, held, 1'b0});
      end
    end
    mask = '0;
    $display("test_mask done");
  endtask
`endif

  initial begin
    test_reset();
    test_manual();
    test_idle();
    test_scan();
    test_dwell0();
    test_dwell_lower();
`ifdef SCAN_MASK_EN
    test_mask();
`endif
    test_random();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
